pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with valid/ready flow control, a 2-entry skid buffer, flush, and NOP bubble insertion. It is the generic replacement for the fixed per-stage registers between IF/ID/EX/MEM/WB. It carries FIELDS words of WIDTH bits. Field 0 is the instruction word. When the stage holds no valid entry, it presents a NOP bubble downstream, so hazard logic can stall or squash any stage uniformly.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_sat_cnt.sv | 20 ++
 rtl/pipe_stage_reg.sv | 130 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, payload field indices and the
// occupancy states used by every stage register.
package pipe_pkg;

  localparam logic [31:0] NOP_INST = 32'h00000033;

  localparam int F_INST = 0;
  localparam int F_PC   = 1;
  localparam int F_RS1  = 2;
  localparam int F_RS2  = 3;

  // Encoded as {vS, vM}; 2'b10 would mean a skid entry with no head and never occurs.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } occ_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter shared by the pipeline performance counters.
// Clear wins over increment; the count sticks at all-ones.
module pipe_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(negedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, 2-entry skid buffer,
// flush, and a NOP bubble presented downstream whenever the stage is empty.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                WIDTH       = 32,
  parameter int                FIELDS      = 4,
  parameter logic [WIDTH-1:0]  BUBBLE_INST = WIDTH'(NOP_INST),
  parameter logic [FIELDS-1:0] KEEP_MASK   = FIELDS'(4'b0010),
  parameter int                CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FIELDS*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FIELDS*WIDTH-1:0] out_data,
  output logic [1:0]              occupancy,
  output logic [CNT_W-1:0]        bubble_cnt
);

  localparam int DW = FIELDS * WIDTH;

  occ_e          state;
  occ_e          state_nxt;
  logic [DW-1:0] m_q;
  logic [DW-1:0] s_q;
  logic          vm;
  logic          vs;
  logic          accept;
  logic          consume;
  logic          load_m_in;
  logic          load_m_s;
  logic          load_s_in;
  logic          bubble_edge;

  assign vm          = state[0];
  assign vs          = state[1];
  // in_ready comes only from registered state, never from out_ready.
  assign in_ready    = ~vs;
  assign out_valid   = vm;
  assign accept      = in_valid & in_ready;
  assign consume     = vm & out_ready;
  assign occupancy   = {1'b0, vm} + {1'b0, vs};
  assign bubble_edge = ~vm;

  always_ff @(negedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s_in = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            load_m_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_m_in = 1'b1;
          end else if (accept) begin
            state_nxt = TWO;
            load_s_in = 1'b1;
          end else if (consume) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            state_nxt = ONE;
            load_m_s  = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Data is left untouched on flush so kept fields still show the last head.
  always_ff @(negedge clk) begin
    if (rst) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (load_m_in) begin
        m_q <= in_data;
      end else if (load_m_s) begin
        m_q <= s_q;
      end
      if (load_s_in) begin
        s_q <= in_data;
      end
    end
  end

  for (genvar f = 0; f < FIELDS; f++) begin : g_field
    if (f == F_INST) begin : g_inst
      assign out_data[f*WIDTH +: WIDTH] = vm ? m_q[f*WIDTH +: WIDTH] : BUBBLE_INST;
    end else if (KEEP_MASK[f]) begin : g_keep
      assign out_data[f*WIDTH +: WIDTH] = m_q[f*WIDTH +: WIDTH];
    end else begin : g_zero
      assign out_data[f*WIDTH +: WIDTH] = vm ? m_q[f*WIDTH +: WIDTH] : '0;
    end
  end

  pipe_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .clr  (rst),
    .inc  (bubble_edge),
    .count(bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a queue-based FIFO model (capacity 2) predicts
// payload order, bubble pattern, occupancy and the saturating bubble counters.
module tb_pipe_stage_reg;

  localparam int DW = 128;
  localparam logic [31:0] NOP = 32'h00000033;
  localparam logic [3:0] KEEP = 4'b0010;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   bubble_cnt;

  logic          in_ready3;
  logic          out_valid3;
  logic [DW-1:0] out_data3;
  logic [1:0]    occupancy3;
  logic [2:0]    bubble_cnt3;

  logic [DW-1:0] q[$];
  logic [DW-1:0] last_head;
  int            mcnt;
  int            mcnt3;
  int            n_checks;
  int            n_pass;

  pipe_stage_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.CNT_W(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready3),
    .in_data   (in_data),
    .out_valid (out_valid3),
    .out_ready (out_ready),
    .out_data  (out_data3),
    .occupancy (occupancy3),
    .bubble_cnt(bubble_cnt3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] make_entry(input logic [31:0] pc);
    return {$urandom(), $urandom(), pc, $urandom()};
  endfunction

  function automatic logic [DW-1:0] exp_out();
    logic [DW-1:0] r;
    if (q.size() > 0) return q[0];
    r = '0;
    r[31:0] = NOP;
    for (int f = 1; f < 4; f++) begin
      if (KEEP[f]) r[f*32 +: 32] = last_head[f*32 +: 32];
    end
    return r;
  endfunction

  // Update the FIFO model from the current inputs, then advance one falling edge.
  task automatic tick();
    bit can_take;
    if (rst) begin
      q.delete();
      last_head = '0;
      mcnt = 0;
      mcnt3 = 0;
    end else begin
      if (q.size() == 0) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt3 < 7) mcnt3++;
      end
      if (flush) begin
        q.delete();
      end else begin
        can_take = (q.size() < 2);
        if (out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && can_take) q.push_back(in_data);
      end
      if (q.size() > 0) last_head = q[0];
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = make_entry(32'h44);
    out_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (out_data !== {96'h0, NOP}) $display("FAIL reset_out_data: got %h want %h", out_data, {96'h0, NOP});
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    else n_pass++;
    n_checks++;
    if (occupancy !== 2'd0) $display("FAIL reset_occupancy: got %0d want 0", occupancy);
    else n_pass++;
    n_checks++;
    if (bubble_cnt !== 16'd0) $display("FAIL reset_bubble_cnt: got %0d want 0", bubble_cnt);
    else n_pass++;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_counter();
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (bubble_cnt !== 16'd5) $display("FAIL cnt_after5: got %0d want 5", bubble_cnt);
    else n_pass++;
    n_checks++;
    if (bubble_cnt3 !== 3'd5) $display("FAIL cnt3_after5: got %0d want 5", bubble_cnt3);
    else n_pass++;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (bubble_cnt3 !== 3'd7) $display("FAIL cnt3_saturate: got %0d want 7", bubble_cnt3);
    else n_pass++;
    n_checks++;
    if (bubble_cnt !== 16'(mcnt)) $display("FAIL cnt_after10: got %0d want %0d", bubble_cnt, mcnt);
    else n_pass++;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = make_entry(32'(i * 4));
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data[63:32] !== 32'(i * 4))
        $display("FAIL stream_pc[%0d]: got v=%0b pc=%h want v=1 pc=%h", i, out_valid, out_data[63:32], i * 4);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b1 || out_data !== exp_out())
        $display("FAIL stream_data[%0d]: got rdy=%0b %h want rdy=1 %h", i, in_ready, out_data, exp_out());
      else n_pass++;
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== {64'h0, 32'd28, NOP})
      $display("FAIL stream_drain: got v=%0b %h want v=0 %h", out_valid, out_data, {64'h0, 32'd28, NOP});
    else n_pass++;
  endtask

  task automatic test_skid();
    logic [31:0] want_pc[3] = '{32'h10, 32'h14, 32'h18};
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = make_entry(32'h10);
    tick();
    in_data = make_entry(32'h14);
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_data[63:32] !== 32'h10)
      $display("FAIL skid_fill: got rdy=%0b occ=%0d pc=%h want rdy=0 occ=2 pc=10", in_ready, occupancy, out_data[63:32]);
    else n_pass++;
    in_data = make_entry(32'h18);
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_data !== exp_out())
      $display("FAIL skid_hold: got rdy=%0b occ=%0d %h want rdy=0 occ=2 %h", in_ready, occupancy, out_data, exp_out());
    else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data[63:32] !== want_pc[i])
        $display("FAIL skid_order[%0d]: got v=%0b pc=%h want v=1 pc=%h", i, out_valid, out_data[63:32], want_pc[i]);
      else n_pass++;
      tick();
      if (i == 1) in_valid = 1'b0;
    end
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL skid_drain: got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy);
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [31:0] head_pc;
    out_ready = 1'b0;
    in_valid = 1'b1;
    head_pc = $urandom();
    in_data = make_entry(head_pc);
    tick();
    in_data = make_entry(32'h1234);
    tick();
    flush = 1'b1;
    out_ready = 1'b1;
    in_data = make_entry(32'hdead);
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1)
      $display("FAIL flush_state: got v=%0b occ=%0d rdy=%0b want v=0 occ=0 rdy=1", out_valid, occupancy, in_ready);
    else n_pass++;
    n_checks++;
    if (out_data !== {64'h0, head_pc, NOP})
      $display("FAIL flush_bubble: got %h want %h", out_data, {64'h0, head_pc, NOP});
    else n_pass++;
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== exp_out())
      $display("FAIL flush_dropped: got v=%0b %h want v=0 %h", out_valid, out_data, exp_out());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = make_entry(32'h200);
    tick();
    in_data = make_entry(32'h204);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    in_data = make_entry(32'h208);
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || bubble_cnt !== 16'd0)
      $display("FAIL rstmid_state: got v=%0b occ=%0d rdy=%0b cnt=%0d want 0/0/1/0", out_valid, occupancy, in_ready, bubble_cnt);
    else n_pass++;
    n_checks++;
    if (out_data !== {96'h0, NOP}) $display("FAIL rstmid_data: got %h want %h", out_data, {96'h0, NOP});
    else n_pass++;
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || bubble_cnt !== 16'd1)
      $display("FAIL rstmid_after: got v=%0b cnt=%0d want v=0 cnt=1", out_valid, bubble_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 15) == 0);
      in_valid = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data = make_entry($urandom());
      tick();
      n_checks++;
      if (out_valid !== (q.size() > 0) || occupancy !== 2'(q.size()) || in_ready !== (q.size() < 2))
        $display("FAIL rand_ctrl[%0d]: got v=%0b occ=%0d rdy=%0b want occ=%0d", i, out_valid, occupancy, in_ready, q.size());
      else n_pass++;
      n_checks++;
      if (out_data !== exp_out())
        $display("FAIL rand_data[%0d]: got %h want %h", i, out_data, exp_out());
      else n_pass++;
      n_checks++;
      if (bubble_cnt !== 16'(mcnt) || bubble_cnt3 !== 3'(mcnt3))
        $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", i, bubble_cnt, bubble_cnt3, mcnt, mcnt3);
      else n_pass++;
    end
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    last_head = '0;
    mcnt = 0;
    mcnt3 = 0;
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_counter();
    test_streaming();
    test_skid();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
